mem_port_arbiter: RTL and testbench

//  Shares the single 128-bit main-memory port between the instruction-cache refill path
//  and the data-cache refill/writeback path. Round-robin arbitration on simultaneous

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one LINE_W-wide main-memory port between the I-cache refill path and
//   the D-cache refill/writeback path. Round-robin on simultaneous requests, one
//   transaction in flight at a time. A watchdog aborts any ISSUE phase that sees
//   no mem_ready within TIMEOUT cycles and raises a sticky error flag.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   reqI, reqAddrI             I-cache read request (level) and line address
//   rdataI, readyI             line to I-cache, 1-cycle completion pulse
//   reqD, weD, reqAddrD,       D-cache request (level), write enable, address,
//   wdataD                     writeback line
//   rdataD, readyD             line to D-cache (reads only), completion pulse
//   mem_req, mem_we, mem_addr, memory request side, held stable through ISSUE
//   mem_wdata
//   mem_rdata, mem_ready       memory response, sampled only while mem_req=1
//   grant_d                    owner of current/last transaction (0=I, 1=D)
//   err_timeout                sticky watchdog error, cleared only by reset
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqI,
    input  logic [ADDR_W-1:0] reqAddrI,
    output logic [LINE_W-1:0] rdataI,
    output logic              readyI,
    input  logic              reqD,
    input  logic              weD,
    input  logic [ADDR_W-1:0] reqAddrD,
    input  logic [LINE_W-1:0] wdataD,
    output logic [LINE_W-1:0] rdataD,
    output logic              readyD,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant_d,
    output logic              err_timeout
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              state_q;
    logic                last_d_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                grant_d_q, mem_req_q, mem_we_q, readyI_q, readyD_q, err_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_wdata_q, rdataI_q, rdataD_q;

    // D wins when it is the only requester, or on a tie when I was served last.
    logic pick_d;
    assign pick_d = reqD && (!reqI || !last_d_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;   // first tie goes to I
            cnt_q       <= '0;
            grant_d_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdataI_q    <= '0;
            rdataD_q    <= '0;
            readyI_q    <= 1'b0;
            readyD_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            readyI_q <= 1'b0;
            readyD_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqI || reqD) begin
                        grant_d_q   <= pick_d;
                        last_d_q    <= pick_d;
                        mem_addr_q  <= pick_d ? reqAddrD : reqAddrI;
                        mem_we_q    <= pick_d && weD;
                        mem_wdata_q <= pick_d ? wdataD : '0;
                        mem_req_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // On abort the owner gets an all-zero line instead of data.
                        if (!mem_we_q) begin
                            if (grant_d_q) rdataD_q <= mem_ready ? mem_rdata : '0;
                            else           rdataI_q <= mem_ready ? mem_rdata : '0;
                        end
                        if (!mem_ready) err_q <= 1'b1;
                        readyI_q  <= !grant_d_q;
                        readyD_q  <= grant_d_q;
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdataI      = rdataI_q;
    assign readyI      = readyI_q;
    assign rdataD      = rdataD_q;
    assign readyD      = readyD_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign grant_d     = grant_d_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Table-driven directed bench for mem_port_arbiter (TIMEOUT=8): each record is
//   one transaction with its memory wait count, plus hand sequences for reset
//   mid-transaction and zero-wait back-to-back reads.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              reqI, reqD, weD;
    logic [ADDR_W-1:0] reqAddrI, reqAddrD;
    logic [LINE_W-1:0] wdataD, mem_rdata;
    logic              mem_ready;
    logic [LINE_W-1:0] rdataI, rdataD, mem_wdata;
    logic              readyI, readyD, mem_req, mem_we, grant_d, err_timeout;
    logic [ADDR_W-1:0] mem_addr;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .reqI(reqI), .reqAddrI(reqAddrI), .rdataI(rdataI), .readyI(readyI),
        .reqD(reqD), .weD(weD), .reqAddrD(reqAddrD), .wdataD(wdataD),
        .rdataD(rdataD), .readyD(readyD),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_d(grant_d), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rI, rD, we;
        logic [ADDR_W-1:0] aI, aD;
        logic [LINE_W-1:0] wd;
        int                waits;     // wait cycles before mem_ready; >= TIMEOUT means never
        logic [LINE_W-1:0] rd;        // what memory returns
        logic              exp_d;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_rdata; // owner's rdata after completion
        logic              exp_err;
        logic              hold;      // keep requests asserted afterwards
    } vec_t;

    vec_t vecs[9];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rI, rD, we, input logic [31:0] aI, aD,
                                input logic [LINE_W-1:0] wd, input int waits,
                                input logic [LINE_W-1:0] rd, input logic exp_d,
                                input logic [31:0] exp_addr, input logic [LINE_W-1:0] exp_rdata,
                                input logic exp_err, hold);
        vec_t v;
        v.rI = rI; v.rD = rD; v.we = we; v.aI = aI; v.aD = aD; v.wd = wd;
        v.waits = waits; v.rd = rd; v.exp_d = exp_d; v.exp_addr = exp_addr;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.hold = hold;
        return v;
    endfunction

    // Called at a negedge while the DUT is in IDLE; returns at the negedge of the
    // following IDLE cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int n_iss;
        string p;
        p = $sformatf("v%0d", idx);
        reqI = v.rI; reqD = v.rD; weD = v.we;
        reqAddrI = v.aI; reqAddrD = v.aD; wdataD = v.wd;
        mem_rdata = v.rd; mem_ready = 1'b0;
        n_iss = (v.waits >= TIMEOUT) ? TIMEOUT : v.waits + 1;
        for (int k = 0; k < n_iss; k++) begin
            @(negedge clk);
            chk({p, " mem_req"}, mem_req, 1'b1);
            chk({p, " mem_addr"}, mem_addr, v.exp_addr);
            chk({p, " mem_we"}, mem_we, v.exp_d & v.we);
            chk({p, " grant_d"}, grant_d, v.exp_d);
            chk({p, " ready_in_issue"}, {readyI, readyD}, 2'b00);
            if (v.exp_d && v.we) chk({p, " mem_wdata"}, mem_wdata, v.wd);
            mem_ready = (k == v.waits);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        if (!v.hold) begin reqI = 1'b0; reqD = 1'b0; weD = 1'b0; end
        chk({p, " resp_mem_req"}, mem_req, 1'b0);
        chk({p, " readyI"}, readyI, !v.exp_d);
        chk({p, " readyD"}, readyD, v.exp_d);
        chk({p, " rdata"}, v.exp_d ? rdataD : rdataI, v.exp_rdata);
        chk({p, " err_timeout"}, err_timeout, v.exp_err);
        @(negedge clk);
        chk({p, " idle_ready"}, {readyI, readyD}, 2'b00);
        chk({p, " idle_mem_req"}, mem_req, 1'b0);
    endtask

    initial begin
        logic [LINE_W-1:0] R0, R1, R2, R3, R5, R6, R7, A5, W1;
        R0 = {4{32'h0000_1111}}; R1 = {4{32'h0000_2222}}; R2 = {4{32'h0000_3333}};
        R3 = {4{32'h0000_4444}}; R5 = {4{32'h5A5A_5A5A}}; R6 = {4{32'h0F0F_0F0F}};
        R7 = {4{32'hCAFE_F00D}}; A5 = {16{8'hA5}};        W1 = {4{32'h1234_5678}};

        //            rI rD we  aI     aD      wd  waits rd        exp_d exp_addr exp_rdata err hold
        vecs[0] = mk(1, 1, 0, 'h100, 'h200,  '0, 0,  R0,       0, 'h100,  R0, 0, 1);
        vecs[1] = mk(1, 1, 0, 'h100, 'h200,  '0, 0,  R1,       1, 'h200,  R1, 0, 1);
        vecs[2] = mk(1, 1, 0, 'h100, 'h200,  '0, 0,  R2,       0, 'h100,  R2, 0, 1);
        vecs[3] = mk(1, 1, 0, 'h100, 'h200,  '0, 0,  R3,       1, 'h200,  R3, 0, 0);
        vecs[4] = mk(1, 0, 0, 'h180, 'h0,    '0, 4,  A5,       0, 'h180,  A5, 0, 0);
        vecs[5] = mk(0, 1, 1, 'h0,   'h1000, W1, 2,  {4{32'hDEAD_BEEF}}, 1, 'h1000, R3, 0, 0);
        vecs[6] = mk(0, 1, 0, 'h0,   'h3000, '0, 1,  R5,       1, 'h3000, R5, 0, 0);
        vecs[7] = mk(1, 0, 0, 'h400, 'h0,    '0, 99, {LINE_W{1'b1}}, 0, 'h400, '0, 1, 0);
        vecs[8] = mk(0, 1, 0, 'h0,   'h500,  '0, 0,  R6,       1, 'h500,  R6, 1, 0);

        reset = 1'b1; reqI = 0; reqD = 0; weD = 0;
        reqAddrI = '0; reqAddrD = '0; wdataD = '0; mem_rdata = '0; mem_ready = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst ready", {readyI, readyD}, 2'b00);
        chk("rst err", err_timeout, 1'b0);
        chk("rst grant_d", grant_d, 1'b0);
        chk("rst mem_addr", mem_addr, '0);
        chk("rst rdata", rdataI | rdataD | mem_wdata, '0);

        // Reset while a D writeback is in ISSUE; a later mem_ready must be ignored.
        reqD = 1; weD = 1; reqAddrD = 'h2000; wdataD = W1;
        @(negedge clk);
        chk("t1 mem_req", mem_req, 1'b1);
        chk("t1 mem_we", mem_we, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t1 rst mem_req", mem_req, 1'b0);
        chk("t1 rst readyD", readyD, 1'b0);
        chk("t1 rst err", err_timeout, 1'b0);
        chk("t1 rst mem_addr", mem_addr, '0);
        reset = 1'b0; reqD = 0; weD = 0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t1 late ready", {readyI, readyD}, 2'b00);
            chk("t1 late mem_req", mem_req, 1'b0);
            @(negedge clk);
        end

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Zero-wait memory, D read request held: one transaction every 3 cycles.
        reqD = 1; weD = 0; reqAddrD = 'h600; mem_rdata = R7; mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("t6 mem_req c%0d", i), mem_req, (i % 3) == 0);
            chk($sformatf("t6 readyD c%0d", i), readyD, (i % 3) == 1);
            chk($sformatf("t6 readyI c%0d", i), readyI, 1'b0);
            if ((i % 3) == 1) chk($sformatf("t6 rdataD c%0d", i), rdataD, R7);
        end
        reqD = 0; mem_ready = 1'b0;
        @(negedge clk);
        chk("t6 end mem_req", mem_req, 1'b0);
        chk("t6 err sticky", err_timeout, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
